// File: rtl/nibble_swap_arbiter.sv
// nibble_swap_arbiter: round-robin sharing of one nibble-swap engine among NREQ requesters
module nibble_swap_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              rsp_valid,
  output logic [7:0]        rsp_data,
  output logic [IDW-1:0]    rsp_id,
  input  logic              rsp_ready,
  output logic [7:0]        swp_in,
  output logic              swp_swap_en,
  input  logic [7:0]        swp_out,
  output logic              busy,
  output logic [15:0]       done_count
);
  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;
  state_t state, state_nxt;
  logic [IDW-1:0] ptr, winner, lat_id;
  logic [IDW:0]   idx;
  logic [7:0]     lat_data;
  logic           accept, finish;
  // scan downward so the last hit is the first valid index at or after ptr
  always_comb begin
    winner = '0;
    idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = {1'b0, ptr} + (IDW+1)'(i);
      idx = idx >= (IDW+1)'(NREQ) ? idx - (IDW+1)'(NREQ) : idx;
      if (req_valid[idx[IDW-1:0]]) winner = idx[IDW-1:0];
    end
  end
  assign accept = reset && state == IDLE && |req_valid;
  assign finish = state == RESP && rsp_ready;
  assign swp_in = lat_data;
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else state <= state_nxt;
  end
  always_comb begin
    state_nxt = state == IDLE    ? (|req_valid ? ISSUE : IDLE) :
                state == ISSUE   ? CAPTURE :
                state == CAPTURE ? RESP :
                                   (rsp_ready ? IDLE : RESP);
  end
  always_comb begin
    req_ready = '0;
    if (accept) req_ready[winner] = 1'b1;
    swp_swap_en = state == ISSUE;
    rsp_valid = state == RESP;
    busy = state != IDLE;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr <= '0;
      lat_id <= '0;
      lat_data <= '0;
      rsp_data <= '0;
      rsp_id <= '0;
      done_count <= '0;
    end else begin
      if (accept) begin
        lat_data <= req_data[8*winner +: 8];
        lat_id <= winner;
      end
      if (state == CAPTURE) begin
        rsp_data <= swp_out;
        rsp_id <= lat_id;
      end
      if (finish) begin
        ptr <= lat_id == IDW'(NREQ - 1) ? '0 : lat_id + 1'b1;
        if (done_count != 16'hFFFF) done_count <= done_count + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_nibble_swap_arbiter.sv
// tb_nibble_swap_arbiter: transaction-level model plus directed scenarios for nibble_swap_arbiter
module tb_nibble_swap_arbiter;
  localparam int NREQ = 4;
  logic clk = 1'b0;
  logic reset, rsp_ready, rsp_valid, swp_swap_en, busy;
  logic [3:0] req_valid, req_ready, sticky;
  logic [31:0] req_data;
  logic [7:0] rsp_data, swp_in, swp_out;
  logic [7:0] eng = 8'h00;
  logic [1:0] rsp_id;
  logic [15:0] done_count;
  int n_cmp = 0, n_bad = 0, cyc = 0;
  int g_q[$], a_cyc[$], r_id[$];
  logic [7:0] r_dat[$];
  // model of the transaction in flight
  bit m_on = 0, m_pend = 0;
  int m_age, m_id, m_ptr, win;
  logic [15:0] m_cnt;
  logic [7:0] m_byte, m_rsp;
  int m_rid;
  logic [15:0] d0;

  nibble_swap_arbiter #(.NREQ(4), .IDW(2)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_id(rsp_id), .rsp_ready(rsp_ready), .swp_in(swp_in),
    .swp_swap_en(swp_swap_en), .swp_out(swp_out), .busy(busy),
    .done_count(done_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (swp_swap_en) eng <= {swp_in[3:0], swp_in[7:4]};
  assign swp_out = eng;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick(2);
    reset = 1'b1;
  endtask

  task automatic wait_resp(input int n);
    int k = 0;
    while (r_dat.size() < n && k < 80) begin
      tick(1);
      k++;
    end
    chk("resp_wait", r_dat.size(), n);
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((busy || req_valid != 0) && k < 80) begin
      tick(1);
      k++;
    end
    chk("idle_wait", {busy, req_valid}, 0);
  endtask

  // requesters drop valid once accepted unless marked sticky
  initial begin
    logic [3:0] acc;
    req_valid = '0;
    forever begin
      @(negedge clk);
      acc = reset ? (req_valid & req_ready) : 4'b0;
      @(posedge clk);
      #1;
      req_valid = req_valid & ~(acc & ~sticky);
    end
  end

  // per-cycle compare against the model, then advance the model to the next edge
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      win = -1;
      for (int i = 0; i < NREQ; i++)
        if (win < 0 && req_valid[(m_ptr + i) % NREQ]) win = (m_ptr + i) % NREQ;
      if (m_on) begin
        chk("req_ready", req_ready, (!m_pend && reset && win >= 0) ? 4'(1 << win) : 4'b0);
        chk("swp_swap_en", swp_swap_en, m_pend && m_age == 1);
        chk("rsp_valid", rsp_valid, m_pend && m_age >= 3);
        chk("busy", busy, m_pend);
        chk("swp_in", swp_in, m_byte);
        chk("rsp_data", rsp_data, m_rsp);
        chk("rsp_id", rsp_id, m_rid);
        chk("done_count", done_count, m_cnt);
      end
      if (reset) begin
        for (int i = 0; i < NREQ; i++)
          if (req_valid[i] && req_ready[i]) begin
            g_q.push_back(i);
            a_cyc.push_back(cyc);
          end
        if (rsp_valid && rsp_ready) begin
          r_id.push_back(int'(rsp_id));
          r_dat.push_back(rsp_data);
        end
      end
      if (!reset) begin
        m_on = 1; m_pend = 0; m_age = 0; m_ptr = 0; m_id = 0;
        m_cnt = 0; m_byte = 0; m_rsp = 0; m_rid = 0;
      end else if (m_on) begin
        if (m_pend) begin
          if (m_age >= 3) begin
            if (rsp_ready) begin
              m_pend = 0;
              m_ptr = (m_id + 1) % NREQ;
              if (m_cnt != 16'hFFFF) m_cnt++;
            end
          end else begin
            if (m_age == 2) begin
              m_rsp = {m_byte[3:0], m_byte[7:4]};
              m_rid = m_id;
            end
            m_age++;
          end
        end else if (win >= 0) begin
          m_pend = 1;
          m_age = 1;
          m_id = win;
          m_byte = req_data[8*win +: 8];
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; rsp_ready = 1'b1; req_data = '0; sticky = '0;
    do_reset();
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_done", done_count, 0);
    // single request
    req_data[7:0] = 8'hA5;
    req_valid[0] = 1'b1;
    #1;
    chk("t1_ready", req_ready, 4'b0001);
    tick(1);
    chk("t1_swap_en", swp_swap_en, 1);
    chk("t1_swp_in", swp_in, 8'hA5);
    tick(1);
    chk("t1_swap_en_low", swp_swap_en, 0);
    tick(1);
    chk("t1_rsp_valid", rsp_valid, 1);
    chk("t1_rsp_data", rsp_data, 8'h5A);
    chk("t1_rsp_id", rsp_id, 0);
    tick(1);
    chk("t1_done", done_count, 1);
    // all four at once
    do_reset();
    g_q.delete(); a_cyc.delete(); r_id.delete(); r_dat.delete();
    req_data = 32'h78563412;
    req_valid = 4'hF;
    wait_resp(4);
    for (int i = 0; i < 4; i++) chk("t2_grant", g_q[i], i);
    chk("t2_rsp0", {r_id[0][7:0], r_dat[0]}, 16'h0021);
    chk("t2_rsp1", {r_id[1][7:0], r_dat[1]}, 16'h0143);
    chk("t2_rsp2", {r_id[2][7:0], r_dat[2]}, 16'h0265);
    chk("t2_rsp3", {r_id[3][7:0], r_dat[3]}, 16'h0387);
    for (int i = 1; i < 4; i++) chk("t2_spacing", a_cyc[i] - a_cyc[i-1], 4);
    wait_idle();
    // back-pressure
    rsp_ready = 1'b0;
    req_data[23:16] = 8'hC3;
    req_valid[2] = 1'b1;
    for (int k = 0; k < 10 && !rsp_valid; k++) tick(1);
    chk("t3_valid_seen", rsp_valid, 1);
    d0 = done_count;
    req_data[7:0] = 8'h11;
    req_valid[0] = 1'b1;
    repeat (5) begin
      tick(1);
      chk("t3_hold_valid", rsp_valid, 1);
      chk("t3_hold_data", rsp_data, 8'h3C);
      chk("t3_hold_id", rsp_id, 2);
      chk("t3_no_ready", req_ready, 0);
    end
    chk("t3_done_hold", done_count, d0);
    rsp_ready = 1'b1;
    tick(1);
    chk("t3_done_inc", done_count, d0 + 16'd1);
    chk("t3_valid_drop", rsp_valid, 0);
    wait_idle();
    // fairness
    do_reset();
    g_q.delete();
    sticky = 4'b0010;
    req_valid[1] = 1'b1;
    for (int k = 0; k < 10 && g_q.size() < 1; k++) tick(1);
    sticky = 4'b1010;
    req_valid[3] = 1'b1;
    for (int k = 0; k < 40 && g_q.size() < 4; k++) tick(1);
    sticky = 4'b0000;
    wait_idle();
    chk("t4_g0", g_q[0], 1);
    chk("t4_g1", g_q[1], 3);
    chk("t4_g2", g_q[2], 1);
    chk("t4_g3", g_q[3], 3);
    // reset during CAPTURE
    do_reset();
    r_id.delete(); r_dat.delete();
    req_data[7:0] = 8'h9C;
    req_valid[0] = 1'b1;
    tick(2);
    chk("t5_busy_capture", busy, 1);
    reset = 1'b0;
    tick(1);
    chk("t5_outs", {busy, rsp_valid, rsp_data, rsp_id, swp_in, swp_swap_en, req_ready}, 0);
    chk("t5_done", done_count, 0);
    reset = 1'b1;
    tick(4);
    chk("t5_no_rsp", r_dat.size(), 0);
    req_data[23:16] = 8'h0F;
    req_valid[2] = 1'b1;
    wait_resp(1);
    chk("t5_data", r_dat[0], 8'hF0);
    chk("t5_id", r_id[0], 2);
    wait_idle();
    chk("t5_done_after", done_count, 1);
    // saturation
    r_id.delete(); r_dat.delete();
    force dut.done_count = 16'hFFFE;
    m_cnt = 16'hFFFE;
    #1;
    release dut.done_count;
    req_data[7:0] = 8'h3C;
    req_valid[0] = 1'b1;
    wait_resp(1);
    wait_idle();
    chk("t6_reach", done_count, 16'hFFFF);
    req_data[15:8] = 8'hE1;
    req_valid[1] = 1'b1;
    wait_resp(2);
    wait_idle();
    chk("t6_sat", done_count, 16'hFFFF);
    chk("t6_data", r_dat[1], 8'h1E);
    chk("t6_id", r_id[1], 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/nibble_swap_arbiter.md
Name: nibble_swap_arbiter

Overview:
- Shares one nibble-swap engine among NREQ requesters.
- Each requester hands over one byte per transaction on a valid/ready handshake.
- The block arbitrates round-robin, sequences the engine (drives its data input and a one-cycle swap enable), captures the swapped byte and returns it with the requester's ID on a valid/ready response port.
- Sits between requester logic and the nibble-swapper instance in the datapath top level; the engine's own reset is wired at top level, not by this block.

Parameters:
- NREQ, 4, number of requesters; legal range 2..8.
- IDW, 2, ID width; must equal clog2(NREQ).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset.
- req_valid  input  NREQ  per-requester request valid.
- req_data  input  8*NREQ  per-requester byte; requester i uses bits [8i+7:8i].
- req_ready  output  NREQ  one-hot accept strobe.
- rsp_valid  output  1  response valid.
- rsp_data  output  8  swapped byte.
- rsp_id  output  IDW  index of the requester being answered.
- rsp_ready  input  1  response consumer ready.
- swp_in  output  8  byte driven to the engine's data input.
- swp_swap_en  output  1  engine swap enable.
- swp_out  input  8  engine registered output.
- busy  output  1  high in any state except IDLE.
- done_count  output  16  completed transactions, saturating.

Behaviour:
- Reset (reset low at a clock edge):
  - state=IDLE, RR pointer=0.
  - req_ready=0, rsp_valid=0, rsp_data=0, rsp_id=0.
  - swp_in=0, swp_swap_en=0, busy=0, done_count=0.
  - Reset mid-transaction abandons it with no response, and done_count is not incremented.
- FSM states: IDLE -> ISSUE -> CAPTURE -> RESP -> IDLE.
- IDLE:
  - If any req_valid is high, the winner is the first asserted index at or after the pointer, scanning upward and wrapping NREQ-1 -> 0.
  - req_ready[winner] is driven high combinationally in this cycle only.
  - req_data of the winner and its index are latched at the edge; go to ISSUE.
  - If no request is valid, stay in IDLE with req_ready all zero.
- ISSUE:
  - swp_in = latched byte; swp_swap_en=1 for exactly this one cycle.
  - The engine registers {in[3:0],in[7:4]} at the end of this cycle; go to CAPTURE.
- CAPTURE:
  - swp_swap_en=0 and swp_in holds the latched byte.
  - Register swp_out into rsp_data and the latched index into rsp_id; go to RESP.
- RESP:
  - rsp_valid=1; rsp_data and rsp_id are held stable until rsp_ready=1.
  - On the handshake edge: rsp_valid drops, pointer = (winner+1) mod NREQ, done_count increments (held at 0xFFFF once reached), go to IDLE.
  - rsp_ready while rsp_valid=0 has no effect.
- Timing:
  - Accept at cycle T, rsp_valid first high at T+3.
  - Minimum spacing between accepts is 4 cycles (with rsp_ready tied high).
- swp_swap_en is never high outside ISSUE.
- req_ready is never asserted outside IDLE.
- Requesters must hold valid and data until ready; deasserting valid before acceptance simply withdraws the request.
- New requests arriving during ISSUE/CAPTURE/RESP wait; none are lost, provided requesters hold valid.
- Simultaneous requests are resolved strictly by the pointer; a continuously requesting index is served at least once every NREQ transactions.

Test Plan:
- Reset, then a single request: req_valid=4'b0001, req_data[7:0]=8'hA5, rsp_ready=1 -> req_ready[0] pulses at T; swp_swap_en high only at T+1 with swp_in=A5; rsp_valid at T+3 with rsp_data=5A, rsp_id=0; done_count=1.
- All four requesters valid simultaneously with bytes 12, 34, 56, 78 held -> grant order 0,1,2,3; responses 21/0, 43/1, 65/2, 87/3 in that order; next accepts every 4 cycles.
- Back-pressure: hold rsp_ready=0 for 5 cycles after rsp_valid -> rsp_valid, rsp_data and rsp_id stay stable; no req_ready pulses during the stall; completion only on the rsp_ready edge.
- Fairness: requester 1 held continuously and requester 3 arriving after the first grant -> grants 1,3,1,3 alternate.
- Reset asserted (low) during CAPTURE -> the next edge gives all outputs 0 and pointer 0; no response is issued, done_count is unchanged at 0, and a subsequent request is served normally.
- Saturation: preload via 65535 transactions (or force) then one more -> done_count stays 0xFFFF and the response is still delivered.
